// File: rtl/aes_sched_pkg.sv
// Shared types and sizing for the S-box share scheduler between round datapath and key schedule.
package aes_sched_pkg;

   localparam int unsigned WORDS_PER_STATE = 4;
   localparam int unsigned WORD_W          = 32;
   localparam int unsigned CNT_W           = 2;
   localparam int unsigned BURST_W         = 2;
   localparam int unsigned BURST_CMP_W     = BURST_W + 1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } sched_state_e;

   typedef logic [WORD_W-1:0]                       word_t;
   typedef logic [WORDS_PER_STATE-1:0][WORD_W-1:0]  state_t;

endpackage

// File: rtl/sbox_share_sched_if.sv
// Request/response bundle for the state (SubBytes) and key (SubWord) requesters.
interface sbox_share_sched_if;
   import aes_sched_pkg::*;

   logic   st_valid;
   logic   st_ready;
   state_t st_data;
   logic   st_done;
   state_t st_out_data;
   logic   key_valid;
   logic   key_ready;
   word_t  key_word;
   logic   key_done;
   word_t  key_out;

   modport master (
      output st_valid, st_data, key_valid, key_word,
      input  st_ready, st_done, st_out_data, key_ready, key_done, key_out
   );

   modport slave (
      input  st_valid, st_data, key_valid, key_word,
      output st_ready, st_done, st_out_data, key_ready, key_done, key_out
   );

endinterface

// File: rtl/subByte.sv
// Combinational 32-bit word substitution: four parallel AES forward S-boxes.
module subByte (
   input  logic [31:0] din,
   output logic [31:0] dout
);

   // Entry 0 sits in the top byte, so entry b lives at bit offset (255-b)*8 = {~b, 3'b000}.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   for (genvar i = 0; i < 4; i++) begin : g_byte
      assign dout[8*i +: 8] = SBOX[{~din[8*i +: 8], 3'b000} +: 8];
   end

endmodule

// File: rtl/sbox_share_sched.sv
// Time-shares one subByte word substituter between a 4-word state request and single key words,
// with a bounded key burst so the state transaction always makes progress.
module sbox_share_sched
   import aes_sched_pkg::*;
#(
   parameter int unsigned MAX_KEY_BURST = 1
) (
   input logic               clk,
   input logic               rst_n,
   sbox_share_sched_if.slave bus
);

   localparam logic [BURST_CMP_W-1:0] BURST_MAX = BURST_CMP_W'(MAX_KEY_BURST);
   localparam logic [CNT_W-1:0]       LAST_WORD = CNT_W'(WORDS_PER_STATE - 1);

   sched_state_e           state;
   logic [CNT_W-1:0]       cnt;
   logic [BURST_W-1:0]     burst;
   logic [BURST_CMP_W-1:0] burst_inc;
   state_t                 buffer;
   state_t                 st_out_q;
   word_t                  key_out_q;
   word_t                  sbox_in;
   word_t                  sbox_out;
   logic                   st_ready_q;
   logic                   key_ready_q;
   logic                   st_done_q;
   logic                   key_done_q;
   logic                   key_grant;
   logic                   st_accept;

   assign key_grant = bus.key_valid && key_ready_q;
   assign st_accept = bus.st_valid && st_ready_q;
   assign burst_inc = BURST_CMP_W'(burst) + BURST_CMP_W'(1);

   // A key grant always owns the S-box; otherwise the next buffered state word goes through.
   assign sbox_in = key_grant ? bus.key_word : buffer[cnt];

   subByte u_subbyte (
      .din  (sbox_in),
      .dout (sbox_out)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         burst       <= '0;
         buffer      <= '0;
         st_out_q    <= '0;
         key_out_q   <= '0;
         st_ready_q  <= 1'b1;
         key_ready_q <= 1'b1;
         st_done_q   <= 1'b0;
         key_done_q  <= 1'b0;
      end else begin
         st_done_q  <= 1'b0;
         key_done_q <= key_grant;
         if (key_grant) begin
            key_out_q <= sbox_out;
         end

         case (state)
            IDLE: begin
               burst       <= '0;
               key_ready_q <= 1'b1;
               if (st_accept) begin
                  buffer     <= bus.st_data;
                  cnt        <= '0;
                  state      <= BUSY;
                  st_ready_q <= 1'b0;
               end else begin
                  st_ready_q <= 1'b1;
               end
            end

            BUSY: begin
               if (key_grant) begin
                  // Word counter stalls; once the burst limit is reached the next slot is forced to state.
                  burst       <= BURST_W'(burst_inc);
                  key_ready_q <= (burst_inc < BURST_MAX);
                  st_ready_q  <= 1'b0;
               end else begin
                  st_out_q[cnt] <= sbox_out;
                  burst         <= '0;
                  key_ready_q   <= 1'b1;
                  if (cnt == LAST_WORD) begin
                     state      <= IDLE;
                     st_done_q  <= 1'b1;
                     st_ready_q <= 1'b1;
                  end else begin
                     cnt        <= cnt + CNT_W'(1);
                     st_ready_q <= 1'b0;
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.st_ready    = st_ready_q;
   assign bus.key_ready   = key_ready_q;
   assign bus.st_done     = st_done_q;
   assign bus.key_done    = key_done_q;
   assign bus.st_out_data = st_out_q;
   assign bus.key_out     = key_out_q;

endmodule

// File: tb/tb_sbox_share_sched.sv
// Scoreboard bench for sbox_share_sched: stimulus pushes expected results, a negedge monitor pops them.
module tb_sbox_share_sched;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sbox_share_sched_if bus ();

   sbox_share_sched #(.MAX_KEY_BURST(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] ALL_63   = {4{32'h63636363}};
   localparam logic [127:0] ALL_16   = {4{32'h16161616}};

   typedef struct {
      logic [127:0] data;
      int           cyc;
   } exp_t;

   exp_t kq[$];
   exp_t sq[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation, in value and cycle.
   always @(negedge clk) begin
      exp_t e;
      if (bus.key_done === 1'b1) begin
         if (kq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL key_done_unexpected: got pulse want none (cycle %0d)", cyc);
         end else begin
            e = kq.pop_front();
            chk("key_out", 128'(bus.key_out), e.data);
            chk("key_done_cycle", 128'(cyc), 128'(e.cyc));
         end
      end
      if (bus.st_done === 1'b1) begin
         if (sq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL st_done_unexpected: got pulse want none (cycle %0d)", cyc);
         end else begin
            e = sq.pop_front();
            chk("st_out_data", 128'(bus.st_out_data), e.data);
            chk("st_done_cycle", 128'(cyc), 128'(e.cyc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0]  krdy;
      logic [31:0] kw [3];
      logic [31:0] ko [3];

      bus.st_valid  = 1'b0;
      bus.st_data   = '0;
      bus.key_valid = 1'b0;
      bus.key_word  = '0;
      rst_n         = 1'b0;
      repeat (3) step();

      // Reset state
      chk("rst_st_done",  128'(bus.st_done), 128'(0));
      chk("rst_key_done", 128'(bus.key_done), 128'(0));
      chk("rst_st_out",   128'(bus.st_out_data), 128'(0));
      chk("rst_key_out",  128'(bus.key_out), 128'(0));
      chk("rst_st_ready", 128'(bus.st_ready), 128'(1));
      rst_n = 1'b1;
      repeat (2) step();

      // Key request alone
      bus.key_valid = 1'b1;
      bus.key_word  = 32'hcf4f3c09;
      chk("key_ready_idle", 128'(bus.key_ready), 128'(1));
      kq.push_back('{128'h8a84eb01, cyc + 1});
      step();
      bus.key_valid = 1'b0;
      repeat (3) step();

      // State request alone: st_ready low C1..C4, done in C5
      bus.st_valid = 1'b1;
      bus.st_data  = FIPS_IN;
      chk("st_ready_c0", 128'(bus.st_ready), 128'(1));
      sq.push_back('{FIPS_OUT, cyc + 5});
      step();
      bus.st_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         chk("st_ready_busy", 128'(bus.st_ready), 128'(0));
         step();
      end
      chk("st_ready_c5", 128'(bus.st_ready), 128'(1));
      repeat (2) step();

      // Key held through a state transaction: slots alternate, done in C9
      krdy          = 10'b1010101011;
      bus.st_valid  = 1'b1;
      bus.st_data   = FIPS_IN;
      bus.key_valid = 1'b1;
      bus.key_word  = 32'h00000000;
      sq.push_back('{FIPS_OUT, cyc + 9});
      for (int i = 0; i <= 9; i++) begin
         chk("key_ready_alt", 128'(bus.key_ready), 128'(krdy[i]));
         chk("st_ready_alt", 128'(bus.st_ready), 128'((i == 0) || (i == 9)));
         if (i <= 8 && krdy[i]) kq.push_back('{128'h63636363, cyc + 1});
         step();
         if (i == 0) bus.st_valid = 1'b0;
         if (i == 8) bus.key_valid = 1'b0;
      end
      repeat (2) step();

      // Back-to-back state transactions
      bus.st_valid = 1'b1;
      bus.st_data  = '0;
      sq.push_back('{ALL_63, cyc + 5});
      step();
      bus.st_valid = 1'b0;
      repeat (4) step();
      chk("st_ready_b2b", 128'(bus.st_ready), 128'(1));
      bus.st_valid = 1'b1;
      bus.st_data  = '1;
      sq.push_back('{ALL_16, cyc + 5});
      step();
      bus.st_valid = 1'b0;
      repeat (6) step();

      // Reset in C2 of a state transaction: no done, outputs cleared
      bus.st_valid = 1'b1;
      bus.st_data  = FIPS_IN;
      step();
      bus.st_valid = 1'b0;
      step();
      rst_n = 1'b0;
      repeat (2) step();
      chk("mid_rst_st_done",   128'(bus.st_done), 128'(0));
      chk("mid_rst_key_done",  128'(bus.key_done), 128'(0));
      chk("mid_rst_st_out",    128'(bus.st_out_data), 128'(0));
      chk("mid_rst_key_out",   128'(bus.key_out), 128'(0));
      chk("mid_rst_st_ready",  128'(bus.st_ready), 128'(1));
      chk("mid_rst_key_ready", 128'(bus.key_ready), 128'(1));
      rst_n = 1'b1;
      repeat (8) step();

      // Key grant in C0 does not delay the state transaction
      bus.st_valid  = 1'b1;
      bus.st_data   = '0;
      bus.key_valid = 1'b1;
      bus.key_word  = 32'h53535353;
      kq.push_back('{128'hedededed, cyc + 1});
      sq.push_back('{ALL_63, cyc + 5});
      step();
      bus.st_valid  = 1'b0;
      bus.key_valid = 1'b0;
      repeat (6) step();

      // Back-to-back key grants in IDLE, one per cycle
      kw[0] = 32'h00000000; ko[0] = 32'h63636363;
      kw[1] = 32'hffffffff; ko[1] = 32'h16161616;
      kw[2] = 32'h53535353; ko[2] = 32'hedededed;
      for (int i = 0; i < 3; i++) begin
         bus.key_valid = 1'b1;
         bus.key_word  = kw[i];
         chk("key_ready_burst_idle", 128'(bus.key_ready), 128'(1));
         kq.push_back('{128'(ko[i]), cyc + 1});
         step();
      end
      bus.key_valid = 1'b0;

      for (int i = 0; i < 20; i++) begin
         if (kq.size() == 0 && sq.size() == 0) break;
         step();
      end
      step();
      chk("key_queue_drained", 128'(kq.size()), 128'(0));
      chk("st_queue_drained",  128'(sq.size()), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
